// File: rtl/sparc_exu_pkg.sv
// Shared definitions for the EXU per-thread register write-back path.
package sparc_exu_pkg;

  localparam int NTHR = 4;

  // True when exactly one thread bit is set; all-zero is not one-hot.
  function automatic logic onehot4(input logic [NTHR-1:0] t);
    logic [NTHR-1:0] t_m1;
    t_m1 = t - 4'd1;
    return (t != '0) && ((t & t_m1) == '0);
  endfunction

endpackage

// File: rtl/sparc_exu_wbpipe_stg.sv
// One write-back pipeline stage: valid/thread/data flops, with a per-thread kill
// applied to the incoming valid bit.
module sparc_exu_wbpipe_stg
  import sparc_exu_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            se,
  input  logic            valid_in,
  input  logic [NTHR-1:0] thr_in,
  input  logic [SIZE-1:0] data_in,
  input  logic [NTHR-1:0] kill,
  output logic            valid,
  output logic [NTHR-1:0] thr,
  output logic [SIZE-1:0] data
);

  // No scan chain is modelled here; scan enable is accepted for port compatibility.
  logic unused_se;
  assign unused_se = se;

  logic valid_next;
  assign valid_next = valid_in & ~|(thr_in & kill);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      thr   <= '0;
      data  <= '0;
    end else begin
      valid <= valid_next;
      thr   <= thr_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/sparc_exu_regwb_ctl.sv
// Thread-tagged E->M->W write-back pipeline for per-thread registers, with
// same-thread read forwarding and a sticky malformed-thread error flag.
module sparc_exu_regwb_ctl
  import sparc_exu_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            se,
  input  logic            wen_e,
  input  logic [3:0]      thr_e,
  input  logic [SIZE-1:0] data_e,
  input  logic [3:0]      flush_thr,
  input  logic [3:0]      thr_rd_e,
  input  logic [SIZE-1:0] data_rd_reg,
  output logic [SIZE-1:0] data_rd_byp,
  output logic            wen_w,
  output logic [3:0]      thr_w,
  output logic [SIZE-1:0] data_in_w,
  output logic            thr_err
);

  logic            thr_e_ok;
  logic            valid_m, valid_w;
  logic [3:0]      thr_m, thr_w_q;
  logic [SIZE-1:0] data_m;

  assign thr_e_ok = onehot4(thr_e);

  sparc_exu_wbpipe_stg #(.SIZE(SIZE)) u_stg_m (
    .clk      (clk),
    .reset    (reset),
    .se       (se),
    .valid_in (wen_e & thr_e_ok),
    .thr_in   (thr_e),
    .data_in  (data_e),
    .kill     (flush_thr),
    .valid    (valid_m),
    .thr      (thr_m),
    .data     (data_m)
  );

  sparc_exu_wbpipe_stg #(.SIZE(SIZE)) u_stg_w (
    .clk      (clk),
    .reset    (reset),
    .se       (se),
    .valid_in (valid_m),
    .thr_in   (thr_m),
    .data_in  (data_m),
    .kill     (flush_thr),
    .valid    (valid_w),
    .thr      (thr_w_q),
    .data     (data_in_w)
  );

  // W is committed: flush never reaches it, only reset does.
  assign wen_w = valid_w;
  assign thr_w = valid_w ? thr_w_q : 4'b0000;

  // Forwarding, youngest first; a flushed M entry must not be forwarded.
  logic rd_ok, m_hit, w_hit;
  assign rd_ok = onehot4(thr_rd_e) & ~reset;
  assign m_hit = rd_ok & valid_m & ~|(thr_m & flush_thr) & (thr_m == thr_rd_e);
  assign w_hit = rd_ok & valid_w & (thr_w_q == thr_rd_e);

  always_comb begin
    data_rd_byp = data_rd_reg;
    if (m_hit)
      data_rd_byp = data_m;
    else if (w_hit)
      data_rd_byp = data_in_w;
  end

  always_ff @(posedge clk) begin
    if (reset)
      thr_err <= 1'b0;
    else if (wen_e & ~thr_e_ok)
      thr_err <= 1'b1;
  end

endmodule

// File: tb/tb_sparc_exu_regwb_ctl.sv
// Directed checks of the write-back pipeline: latency, forwarding, flush, error, reset.
module tb_sparc_exu_regwb_ctl;

  logic       clk = 1'b0;
  logic       reset, se, wen_e;
  logic [3:0] thr_e, flush_thr, thr_rd_e;
  logic [2:0] data_e, data_rd_reg;
  logic [2:0] data_rd_byp, data_in_w;
  logic       wen_w, thr_err;
  logic [3:0] thr_w;

  int pass_cnt = 0;
  int total_cnt = 0;

  sparc_exu_regwb_ctl #(.SIZE(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .se          (se),
    .wen_e       (wen_e),
    .thr_e       (thr_e),
    .data_e      (data_e),
    .flush_thr   (flush_thr),
    .thr_rd_e    (thr_rd_e),
    .data_rd_reg (data_rd_reg),
    .data_rd_byp (data_rd_byp),
    .wen_w       (wen_w),
    .thr_w       (thr_w),
    .data_in_w   (data_in_w),
    .thr_err     (thr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge,
  // outputs are sampled mid-cycle via settle().
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle();
    wen_e = 1'b0; thr_e = 4'b0; data_e = 3'b0; flush_thr = 4'b0;
  endtask

  initial begin
    reset = 1'b1; se = 1'b0; idle();
    thr_rd_e = 4'b0000; data_rd_reg = 3'b110;
    tick(); tick(); settle();
    chk("rst_wen_w", {7'b0, wen_w}, 8'd0);
    chk("rst_thr_w", {4'b0, thr_w}, 8'd0);
    chk("rst_data_in_w", {5'b0, data_in_w}, 8'd0);
    chk("rst_thr_err", {7'b0, thr_err}, 8'd0);
    chk("rst_byp", {5'b0, data_rd_byp}, 8'h6);
    reset = 1'b0;
    tick();

    // Basic latency: thread 2 write appears two cycles later for one cycle.
    wen_e = 1'b1; thr_e = 4'b0100; data_e = 3'b101;
    tick(); idle(); settle();
    chk("lat_t1_wen", {7'b0, wen_w}, 8'd0);
    chk("lat_t1_thr", {4'b0, thr_w}, 8'd0);
    tick(); settle();
    chk("lat_t2_wen", {7'b0, wen_w}, 8'd1);
    chk("lat_t2_thr", {4'b0, thr_w}, 8'h4);
    chk("lat_t2_data", {5'b0, data_in_w}, 8'h5);
    tick(); settle();
    chk("lat_t3_wen", {7'b0, wen_w}, 8'd0);
    chk("lat_t3_thr", {4'b0, thr_w}, 8'd0);
    tick();

    // Back-to-back thread 1 writes with forwarding.
    thr_rd_e = 4'b0010; data_rd_reg = 3'b000;
    wen_e = 1'b1; thr_e = 4'b0010; data_e = 3'b011;
    settle();
    chk("byp_t0_storage", {5'b0, data_rd_byp}, 8'h0);
    tick();
    wen_e = 1'b1; thr_e = 4'b0010; data_e = 3'b110;
    settle();
    chk("byp_t1_m", {5'b0, data_rd_byp}, 8'h3);
    tick(); idle(); settle();
    chk("byp_t2_m_over_w", {5'b0, data_rd_byp}, 8'h6);
    chk("b2b_t2_wen", {7'b0, wen_w}, 8'd1);
    chk("b2b_t2_data", {5'b0, data_in_w}, 8'h3);
    thr_rd_e = 4'b0011; #1;
    chk("byp_not_onehot", {5'b0, data_rd_byp}, 8'h0);
    thr_rd_e = 4'b0000; #1;
    chk("byp_zero_thr", {5'b0, data_rd_byp}, 8'h0);
    thr_rd_e = 4'b0010;
    tick(); settle();
    chk("byp_t3_w", {5'b0, data_rd_byp}, 8'h6);
    chk("b2b_t3_data", {5'b0, data_in_w}, 8'h6);
    tick(); settle();
    chk("byp_t4_storage", {5'b0, data_rd_byp}, 8'h0);
    tick();

    // Flush kills thread 2 in M, thread 0 write issued under the same flush survives.
    wen_e = 1'b1; thr_e = 4'b0100; data_e = 3'b111;
    tick();
    flush_thr = 4'b0100; wen_e = 1'b1; thr_e = 4'b0001; data_e = 3'b010;
    thr_rd_e = 4'b0100; data_rd_reg = 3'b001;
    settle();
    chk("flush_no_fwd", {5'b0, data_rd_byp}, 8'h1);
    tick(); idle(); settle();
    chk("flush_t2_wen", {7'b0, wen_w}, 8'd0);
    chk("flush_t2_thr", {4'b0, thr_w}, 8'd0);
    tick(); settle();
    chk("flush_other_wen", {7'b0, wen_w}, 8'd1);
    chk("flush_other_thr", {4'b0, thr_w}, 8'h1);
    chk("flush_other_data", {5'b0, data_in_w}, 8'h2);
    tick();

    // Flush never kills W; W still forwards.
    wen_e = 1'b1; thr_e = 4'b1000; data_e = 3'b011;
    tick(); idle();
    tick();
    flush_thr = 4'b1000; thr_rd_e = 4'b1000; data_rd_reg = 3'b000;
    settle();
    chk("wflush_wen", {7'b0, wen_w}, 8'd1);
    chk("wflush_thr", {4'b0, thr_w}, 8'h8);
    chk("wflush_byp", {5'b0, data_rd_byp}, 8'h3);
    tick(); idle();

    // Flush in E of the same thread drops the request.
    wen_e = 1'b1; thr_e = 4'b0001; data_e = 3'b101; flush_thr = 4'b0001;
    tick(); idle();
    tick(); settle();
    chk("eflush_wen", {7'b0, wen_w}, 8'd0);
    tick();

    // Non-one-hot thread: dropped, sticky error until reset.
    wen_e = 1'b1; thr_e = 4'b0011; data_e = 3'b111;
    settle();
    chk("err_before", {7'b0, thr_err}, 8'd0);
    tick(); idle(); settle();
    chk("err_set", {7'b0, thr_err}, 8'd1);
    tick(); settle();
    chk("err_dropped_wen", {7'b0, wen_w}, 8'd0);
    chk("err_sticky", {7'b0, thr_err}, 8'd1);
    reset = 1'b1;
    tick(); settle();
    chk("err_cleared", {7'b0, thr_err}, 8'd0);
    reset = 1'b0;
    tick();

    // Reset with M and W both valid discards everything.
    wen_e = 1'b1; thr_e = 4'b0001; data_e = 3'b001;
    tick();
    wen_e = 1'b1; thr_e = 4'b0010; data_e = 3'b010;
    tick(); idle();
    reset = 1'b1; thr_rd_e = 4'b0010; data_rd_reg = 3'b100;
    settle();
    chk("rst_mid_byp", {5'b0, data_rd_byp}, 8'h4);
    tick(); settle();
    chk("rst_mid_wen", {7'b0, wen_w}, 8'd0);
    chk("rst_mid_thr", {4'b0, thr_w}, 8'd0);
    reset = 1'b0;
    tick(); settle();
    chk("rst_after1_wen", {7'b0, wen_w}, 8'd0);
    tick(); settle();
    chk("rst_after2_wen", {7'b0, wen_w}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
